// File: rtl/if_fetch_stage.sv
// if_fetch_stage: LoongArch IF stage with pre-IF next-PC, inst SRAM request and decode hold buffer.
// Optional macro IF_PERF_CNT_EN adds perf_fetch_cnt/perf_cancel_cnt counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_allow_in,
  output logic        if_to_id_valid,
  output logic [63:0] if_to_id_bus,
  input  logic [32:0] id_to_if_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_cancel_cnt
`endif
);
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic        br_buf_valid_q, br_buf_valid_d;
  logic [31:0] br_buf_target_q, br_buf_target_d;
  logic        br_done_q, br_done_d;
  logic        br_taken, br_take, if_allow_in;
  logic [31:0] br_target, nextpc, inst;
  assign br_taken        = id_to_if_bus[32];
  assign br_target       = id_to_if_bus[31:0];
  // a redirect is honoured once per branch; br_done masks it while decode stalls
  assign br_take         = br_taken & ~br_done_q;
  assign if_allow_in     = ~if_valid_q | id_allow_in | br_take;
  assign nextpc          = br_take ? br_target : br_buf_valid_q ? br_buf_target_q : if_pc_q + 32'd4;
  assign inst_sram_en    = ~reset & if_allow_in;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;
  assign inst            = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign if_to_id_valid  = ~reset & if_valid_q & ~br_take;
  assign if_to_id_bus    = {if_pc_q, inst};
  always_comb begin
    if_valid_d       = if_valid_q;
    if_pc_d          = if_pc_q;
    inst_buf_d       = inst_buf_q;
    inst_buf_valid_d = inst_buf_valid_q;
    br_buf_valid_d   = br_buf_valid_q;
    br_buf_target_d  = br_buf_target_q;
    br_done_d        = id_allow_in ? 1'b0 : (br_take | br_done_q);
    if (br_take && !if_allow_in) begin
      br_buf_valid_d  = 1'b1;
      br_buf_target_d = br_target;
    end else if (inst_sram_en && br_buf_valid_q && nextpc == br_buf_target_q)
      br_buf_valid_d = 1'b0;
    if (inst_sram_en) begin
      if_valid_d       = 1'b1;
      if_pc_d          = nextpc;
      inst_buf_valid_d = 1'b0;
    end else if (if_valid_q && (br_take || id_allow_in))
      if_valid_d = 1'b0;
    else if (if_valid_q && !inst_buf_valid_q) begin
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = inst_sram_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid_q       <= 1'b0;
      if_pc_q          <= RESET_PC - 32'd4;
      inst_buf_q       <= 32'b0;
      inst_buf_valid_q <= 1'b0;
      br_buf_valid_q   <= 1'b0;
      br_buf_target_q  <= 32'b0;
      br_done_q        <= 1'b0;
    end else begin
      if_valid_q       <= if_valid_d;
      if_pc_q          <= if_pc_d;
      inst_buf_q       <= inst_buf_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      br_buf_valid_q   <= br_buf_valid_d;
      br_buf_target_q  <= br_buf_target_d;
      br_done_q        <= br_done_d;
    end
  end
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, cancel_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= 32'b0;
      cancel_cnt_q <= 32'b0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_q + {31'b0, inst_sram_en};
      cancel_cnt_q <= cancel_cnt_q + {31'b0, if_valid_q & br_take};
    end
  end
  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_cancel_cnt = cancel_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and randomized checks of if_fetch_stage against an SRAM model and a fetch-stream model.
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  logic        clk, reset, id_allow_in, if_to_id_valid, inst_sram_en;
  logic [63:0] if_to_id_bus;
  logic [32:0] id_to_if_bus;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  int errors = 0, checks = 0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_cancel_cnt;
`endif
  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .id_allow_in(id_allow_in),
    .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus),
    .id_to_if_bus(id_to_if_bus), .inst_sram_en(inst_sram_en),
    .inst_sram_we(inst_sram_we), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_cancel_cnt(perf_cancel_cnt)
`endif
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == RST_PC) ? 32'h02800421 : (a * 32'h9e3779b1) ^ 32'h5a5a5a5a;
  endfunction
  // synchronous SRAM: data valid the cycle after a request, garbage otherwise
  always @(posedge clk) inst_sram_rdata <= inst_sram_en ? memf(inst_sram_addr) : 32'hdeadbeef;
  task automatic do_reset();
    reset = 1; id_allow_in = 1; id_to_if_bus = '0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  task automatic test_reset();
    reset = 1; id_allow_in = 1; id_to_if_bus = {1'b1, 32'h1c000500};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (inst_sram_en !== 1'b0 || if_to_id_valid !== 1'b0) begin
        errors++; $display("FAIL reset_outputs: en=%b valid=%b required en=0 valid=0", inst_sram_en, if_to_id_valid);
      end
      @(negedge clk);
    end
    id_to_if_bus = '0; reset = 0;
  endtask
  task automatic test_sequential();
    logic [31:0] exp_addr [3] = '{32'h1c000000, 32'h1c000004, 32'h1c000008};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (inst_sram_en !== 1'b1 || inst_sram_addr !== exp_addr[i]) begin
        errors++; $display("FAIL seq_addr%0d: en=%b addr=%h required en=1 addr=%h", i, inst_sram_en, inst_sram_addr, exp_addr[i]);
      end
      checks++;
      if (if_to_id_valid !== (i != 0) || (i != 0 && if_to_id_bus[63:32] !== exp_addr[i-1])) begin
        errors++; $display("FAIL seq_valid%0d: valid=%b pc=%h", i, if_to_id_valid, if_to_id_bus[63:32]);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_stall();
    do_reset();
    @(negedge clk);
    id_allow_in = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (if_to_id_valid !== 1'b1 || if_to_id_bus !== {32'h1c000000, 32'h02800421} || inst_sram_en !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: valid=%b bus=%h en=%b required valid=1 bus=1c00000002800421 en=0", i, if_to_id_valid, if_to_id_bus, inst_sram_en);
      end
      @(negedge clk);
    end
    id_allow_in = 1;
    #1;
    checks++;
    if (if_to_id_bus[63:32] !== 32'h1c000000 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000004) begin
      errors++; $display("FAIL stall_release: pc=%h en=%b addr=%h required pc=1c000000 en=1 addr=1c000004", if_to_id_bus[63:32], inst_sram_en, inst_sram_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (if_to_id_valid !== 1'b1 || if_to_id_bus !== {32'h1c000004, memf(32'h1c000004)}) begin
      errors++; $display("FAIL stall_next: valid=%b bus=%h required valid=1 bus=%h", if_to_id_valid, if_to_id_bus, {32'h1c000004, memf(32'h1c000004)});
    end
  endtask
  task automatic test_branch();
    do_reset();
    repeat (3) @(negedge clk);
    id_to_if_bus = {1'b1, 32'h1c000100};
    #1;
    checks++;
    if (if_to_id_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin
      errors++; $display("FAIL branch_cancel: valid=%b en=%b addr=%h required valid=0 en=1 addr=1c000100", if_to_id_valid, inst_sram_en, inst_sram_addr);
    end
    @(negedge clk);
    id_to_if_bus = '0;
    #1;
    checks++;
    if (if_to_id_valid !== 1'b1 || if_to_id_bus !== {32'h1c000100, memf(32'h1c000100)} || inst_sram_addr !== 32'h1c000104) begin
      errors++; $display("FAIL branch_target: valid=%b bus=%h addr=%h required target 1c000100 then addr 1c000104", if_to_id_valid, if_to_id_bus, inst_sram_addr);
    end
  endtask
  task automatic test_branch_held();
    int reqs = 0;
    do_reset();
    @(negedge clk);
    id_allow_in = 0; id_to_if_bus = {1'b1, 32'h1c000200};
    for (int i = 0; i < 3; i++) begin
      #1;
      if (inst_sram_en && inst_sram_addr == 32'h1c000200) reqs++;
      if (i > 0) begin
        checks++;
        if (if_to_id_valid !== 1'b1 || if_to_id_bus[63:32] !== 32'h1c000200) begin
          errors++; $display("FAIL held_valid%0d: valid=%b pc=%h required valid=1 pc=1c000200", i, if_to_id_valid, if_to_id_bus[63:32]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (reqs != 1) begin
      errors++; $display("FAIL held_requests: got %0d requests to 1c000200, required 1", reqs);
    end
    reset = 1;
    @(negedge clk);
    reset = 0; id_to_if_bus = '0; id_allow_in = 1;
    #1;
    checks++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST_PC || if_to_id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid: en=%b addr=%h valid=%b required en=1 addr=1c000000 valid=0", inst_sram_en, inst_sram_addr, if_to_id_valid);
    end
    @(negedge clk);
  endtask
  // model: IF holds at most one fetched pc; decode must only ever see {pc, mem[pc]}
  task automatic test_random();
    bit held = 0, done = 0, take, allow, br, exp_valid, can_fetch;
    logic [31:0] held_pc = 0, seq_pc = RST_PC, tgt, exp_addr;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      allow = $urandom_range(0, 3) != 0;
      br = $urandom_range(0, 4) == 0;
      tgt = RST_PC + {22'b0, 8'($urandom), 2'b00};
      id_allow_in = allow; id_to_if_bus = {br, tgt};
      #1;
      take = br && !done;
      exp_valid = held && !take;
      can_fetch = !held || allow || take;
      exp_addr = take ? tgt : seq_pc;
      checks++;
      if (if_to_id_valid !== exp_valid || (exp_valid && if_to_id_bus !== {held_pc, memf(held_pc)})) begin
        errors++; $display("FAIL rand_bus c%0d: valid=%b bus=%h required valid=%b bus=%h", c, if_to_id_valid, if_to_id_bus, exp_valid, {held_pc, memf(held_pc)});
      end
      checks++;
      if (inst_sram_en !== can_fetch || (can_fetch && inst_sram_addr !== exp_addr) || inst_sram_we !== 4'b0 || inst_sram_wdata !== 32'b0) begin
        errors++; $display("FAIL rand_req c%0d: en=%b addr=%h required en=%b addr=%h", c, inst_sram_en, inst_sram_addr, can_fetch, exp_addr);
      end
      if (can_fetch) begin
        held = 1; held_pc = exp_addr; seq_pc = exp_addr + 4;
      end
      done = allow ? 0 : (take | done);
      @(negedge clk);
    end
    id_to_if_bus = '0; id_allow_in = 1;
  endtask
`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      id_to_if_bus = (i == 4) ? {1'b1, 32'h1c000300} : '0;
      @(negedge clk);
    end
    id_to_if_bus = '0;
    #1;
    checks++;
    if (perf_fetch_cnt !== 32'd10 || perf_cancel_cnt !== 32'd1) begin
      errors++; $display("FAIL perf_cnt: fetch=%0d cancel=%0d required fetch=10 cancel=1", perf_fetch_cnt, perf_cancel_cnt);
    end
    @(negedge clk);
  endtask
`endif
  initial begin
    reset = 1; id_allow_in = 1; id_to_if_bus = '0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    @(negedge clk);
    test_branch();
    @(negedge clk);
    test_branch_held();
    test_random();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage LoongArch pipeline: produces the {pc, inst} bus consumed by the decode stage and consumes the decode stage's {br_taken, br_target} redirect bus.
- Contains the pre-IF next-PC logic, the synchronous instruction-SRAM request/response, and an instruction hold buffer so that decode back-pressure never loses fetched data.
- Handles taken-branch cancellation of the wrong-path instruction and redirects that arrive while pre-IF is blocked.

Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- id_allow_in  input  1  decode stage can accept an instruction this cycle.
- if_to_id_valid  output  1  if_to_id_bus holds a valid, non-cancelled instruction.
- if_to_id_bus  output  64  {pc[31:0], inst[31:0]}.
- id_to_if_bus  input  33  {br_taken, br_target[31:0]}; combinational from decode, may stay asserted several cycles while decode stalls.
- inst_sram_en  output  1  fetch request.
- inst_sram_we  output  4  always 4'b0.
- inst_sram_addr  output  32  fetch address (nextpc).
- inst_sram_wdata  output  32  always 32'b0.
- inst_sram_rdata  input  32  read data, valid the cycle after a request.

Behaviour:
- Clock clk; reset is synchronous, active-high on signal reset.
- State: if_valid, if_pc, inst_buf and inst_buf_valid, br_buf_valid and br_buf_target, br_done.
- Reset values:
  - if_valid=0, if_pc=RESET_PC-4, inst_buf_valid=0, br_buf_valid=0, br_done=0.
  - While reset=1: inst_sram_en=0 and if_to_id_valid=0.
- Branch acceptance: br_taken is honoured only when br_done=0; call this br_take = br_taken & ~br_done.
- br_done:
  - Set at a clock edge when br_take=1.
  - Cleared at any edge where id_allow_in=1 (the branch leaves decode).
  - If set and clear occur on the same edge, clear wins.
- Pre-IF:
  - Request condition: to_fs_valid = ~reset.
  - nextpc priority: br_take ? br_target : br_buf_valid ? br_buf_target : if_pc+4.
  - inst_sram_en = to_fs_valid & if_allow_in; inst_sram_addr = nextpc.
- if_allow_in = ~if_valid | id_allow_in | br_take (a cancelled instruction frees IF immediately).
- Blocked redirect: if br_take=1 while if_allow_in=0, then br_buf_valid<=1 and br_buf_target<=br_target.
- br_buf_valid clears on the edge where a request with nextpc=br_buf_target is issued.
- IF register update, on an edge with inst_sram_en=1:
  - if_valid<=1, if_pc<=nextpc, inst_buf_valid<=0.
  - Otherwise, if id_allow_in=1 and if_to_id_valid=1: if_valid<=0.
- Cancel:
  - if_to_id_valid = if_valid & ~br_take.
  - A cancelled instruction is never seen by decode; it is overwritten by the target fetch or, if no new fetch is issued, dropped (if_valid<=0).
- Hold buffer:
  - First cycle after a fetch: inst = inst_sram_rdata.
  - If that cycle ends without decode accepting (if_valid=1, id_allow_in=0), capture inst_buf<=inst_sram_rdata and set inst_buf_valid=1.
  - While inst_buf_valid=1, inst = inst_buf.
- Latency: request at cycle N leads to if_to_id_valid at cycle N+1.
- Throughput: one instruction per cycle with no stalls.
- Taken-branch penalty: exactly one bubble.
- Simultaneous events:
  - br_take together with id_allow_in=1: the target is fetched, the IF instruction is cancelled, and br_done stays 0.
  - reset asserted mid-stall or mid-redirect discards all state; the first fetch after reset deasserts is RESET_PC.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_cancel_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on each edge with inst_sram_en=1.
  - perf_cancel_cnt increments on each edge with if_valid=1 and br_take=1.
  - Both counters wrap from 32'hffffffff to 0.
- Undefined: neither port nor the counter logic exists.

Test Plan:
- Reset release, id_allow_in=1 held: inst_sram_addr sequence 1c000000, 1c000004, 1c000008.
  - if_to_id_valid first rises one cycle after the first request, with pc=1c000000.
- Fetch 1c000000 (rdata 0x02800421), hold id_allow_in=0 for 3 cycles: bus remains {1c000000, 02800421} while rdata changes to 0xdeadbeef.
  - inst_sram_en=0 during the stall; pc 1c000004 is presented only after id_allow_in=1.
- br_taken=1, target 1c000100, with id_allow_in=1 and IF holding 1c000008: if_to_id_valid=0 that cycle, and the next request address is 1c000100.
  - Decode never receives 1c000008.
- br_taken held 3 cycles, target 1c000200, id_allow_in=0: exactly one request to 1c000200.
  - if_to_id_valid stays 1 for pc 1c000200 after br_done sets; no repeated cancel.
- Reset pulsed while br_buf_valid=1: the first request after reset is 1c000000, not the buffered target.
- IF_PERF_CNT_EN defined, 10 fetches including 1 taken branch: perf_fetch_cnt=10, perf_cancel_cnt=1.
